// File: rtl/tge_tx_packetizer_pkg.sv
// Shared types and constants for the 10GbE TX packetizer.
package tge_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  // Header word layout: {seq[31:0], len[15:0], 16'h0000}
  localparam int SEQ_MSB   = 63;
  localparam int LEN_MSB   = 31;
  localparam int OVF_CNT_W = 16;

endpackage

// File: rtl/tge_tx_packetizer_if.sv
// Application-side TX bus of the 10GbE core; master = packetizer, slave = core.
interface tge_tx_packetizer_if;
  import tge_pkt_pkg::*;

  logic        tx_valid;
  logic        tx_end_of_frame;
  logic [63:0] tx_data;
  logic [31:0] tx_dest_ip;
  logic [15:0] tx_dest_port;
  logic        tx_afull;
  logic        tx_overflow;

  modport master (
    output tx_valid, tx_end_of_frame, tx_data, tx_dest_ip, tx_dest_port,
    input  tx_afull, tx_overflow
  );

  modport slave (
    input  tx_valid, tx_end_of_frame, tx_data, tx_dest_ip, tx_dest_port,
    output tx_afull, tx_overflow
  );

endinterface

// File: rtl/tge_sat_counter.sv
// Event counter that increments on a single-cycle pulse and sticks at all-ones.
module tge_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tge_tx_packetizer.sv
// Cuts a 64-bit sample stream into fixed-length UDP payload frames for the 10GbE core.
// Optional sequence/length header word per frame when TGE_PKT_HEADER_EN is defined.
//
// state   | meaning
// IDLE    | waiting for enable, !tx_afull and a valid word; no word consumed
// HEADER  | one-cycle header word emission (TGE_PKT_HEADER_EN only)
// PAYLOAD | accepting stream words until length reached or in_last
module tge_tx_packetizer
  import tge_pkt_pkg::*;
#(
  parameter int PAYLOAD_WORDS = 128,
  parameter int CNT_W         = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_enable,
  input  logic [31:0]          cfg_dest_ip,
  input  logic [15:0]          cfg_dest_port,
  input  logic                 in_valid,
  input  logic [63:0]          in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  tge_tx_packetizer_if.master  tx,
  output logic [31:0]          frame_count,
  output logic [OVF_CNT_W-1:0] overflow_count
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] word_cnt;
  logic             start;
  logic             accept;
  logic             frame_end;
  logic             ovf_prev;
  logic             ovf_edge;
`ifdef TGE_PKT_HEADER_EN
  logic [31:0]      seq;
`endif

  assign in_ready  = (state == PAYLOAD);
  assign accept    = in_valid && in_ready;
  assign frame_end = accept && (in_last || (word_cnt == CNT_W'(PAYLOAD_WORDS - 1)));
  // tx_afull only gates the start; once a frame is running it is ignored
  assign start     = (state == IDLE) && cfg_enable && !tx.tx_afull && in_valid;
  assign ovf_edge  = tx.tx_overflow && !ovf_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef TGE_PKT_HEADER_EN
          state_nx = HEADER;
`else
          state_nx = PAYLOAD;
`endif
        end
      end
`ifdef TGE_PKT_HEADER_EN
      HEADER:  state_nx = PAYLOAD;
`endif
      PAYLOAD: begin
        if (frame_end) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx.tx_valid        <= 1'b0;
      tx.tx_end_of_frame <= 1'b0;
      tx.tx_data         <= '0;
      tx.tx_dest_ip      <= '0;
      tx.tx_dest_port    <= '0;
      word_cnt           <= '0;
      frame_count        <= '0;
      ovf_prev           <= 1'b0;
`ifdef TGE_PKT_HEADER_EN
      seq                <= '0;
`endif
    end else begin
      tx.tx_valid        <= accept;
      tx.tx_end_of_frame <= frame_end;
      ovf_prev           <= tx.tx_overflow;
      if (accept) begin
        tx.tx_data <= in_data;
      end
      if (start) begin
        tx.tx_dest_ip   <= cfg_dest_ip;
        tx.tx_dest_port <= cfg_dest_port;
        word_cnt        <= '0;
      end else if (accept) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (frame_end) begin
        frame_count <= frame_count + 32'd1;
      end
`ifdef TGE_PKT_HEADER_EN
      if (state == HEADER) begin
        tx.tx_valid                  <= 1'b1;
        tx.tx_data[SEQ_MSB -: 32]    <= seq;
        tx.tx_data[LEN_MSB -: 16]    <= 16'(PAYLOAD_WORDS);
        tx.tx_data[LEN_MSB-16:0]     <= '0;
      end
      if (frame_end) begin
        seq <= seq + 32'd1;
      end
`endif
    end
  end

  tge_sat_counter #(
    .WIDTH (OVF_CNT_W)
  ) u_ovf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ovf_edge),
    .count (overflow_count)
  );

endmodule

// File: doc/tge_tx_packetizer.md
Name: tge_tx_packetizer

Overview:
- Upstream feeder for the 10GbE core's application TX port (tx_valid/tx_end_of_frame/tx_data/tx_dest_ip/tx_dest_port).
- Cuts a continuous 64-bit sample stream into UDP payload frames of fixed length, with early termination via in_last.
- Gates frame starts on the core's tx_afull and counts tx_overflow events for software.
- Runs entirely in the application clock domain, i.e. the same clk that drives the core's app side.

Parameters:
- PAYLOAD_WORDS, 128, 64-bit words per frame (2..1024)
- CNT_W, 10, width of the word counter; must be >= clog2(PAYLOAD_WORDS)

Ports:
- clk  input  1  application clock
- rst  input  1  asynchronous reset, active-high
- cfg_enable  input  1  permits new frames to start
- cfg_dest_ip  input  32  destination IP, sampled at frame start
- cfg_dest_port  input  16  destination port, sampled at frame start
- in_valid  input  1  stream word valid
- in_data  input  64  stream word
- in_last  input  1  forces end of frame on this word
- in_ready  output  1  word accepted when in_valid && in_ready
- tx_valid  output  1  to core tx_valid
- tx_end_of_frame  output  1  to core tx_end_of_frame
- tx_data  output  64  to core tx_data
- tx_dest_ip  output  32  to core tx_dest_ip
- tx_dest_port  output  16  to core tx_dest_port
- tx_afull  input  1  from core; TX buffer almost full
- tx_overflow  input  1  from core; frame lost
- frame_count  output  32  frames completed, wraps
- overflow_count  output  16  tx_overflow rising edges, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): state IDLE, word_cnt=0, seq=0, all outputs 0, in_ready=0.
- All tx_* outputs are registered: a word accepted in cycle N appears on tx_data with tx_valid=1 in cycle N+1. tx_valid=0 in any cycle with no load.
- in_ready is combinational: 1 iff state==PAYLOAD.
- IDLE: start when cfg_enable && !tx_afull && in_valid. On start, latch cfg_dest_ip/port into tx_dest_ip/port, clear word_cnt, and go to PAYLOAD (or HEADER, see Optional Feature). The word is not consumed in IDLE.
- PAYLOAD: on each accept, load tx_data=in_data and tx_valid=1, then word_cnt++.
  - Frame ends if word_cnt==PAYLOAD_WORDS-1 or in_last. On frame end: tx_end_of_frame=1 on that word, seq++, frame_count++, return to IDLE.
- Gaps: in_valid=0 in PAYLOAD emits tx_valid=0 and holds state; gaps are legal on the core interface.
- tx_afull is ignored mid-frame (the core's afull margin covers one frame). It blocks only the start of the next frame; in_ready stays 0 while blocked.
- cfg_enable deasserted mid-frame: the current frame completes normally and no new frame starts.
- cfg_dest_* changes mid-frame have no effect until the next start.
- Minimum gap between frames is one IDLE cycle, so tx_end_of_frame is never followed by tx_valid in the next cycle.
- tx_overflow: detected via a registered previous value. Each 0->1 edge increments overflow_count, which saturates (no wrap).
- frame_count wraps 32'hFFFFFFFF -> 0.

Optional Feature:
- Macro TGE_PKT_HEADER_EN.
- Defined:
  - The start transition goes IDLE->HEADER.
  - HEADER lasts one cycle and loads tx_valid=1, tx_data={seq[31:0], PAYLOAD_WORDS[15:0], 16'h0000}, then goes to PAYLOAD. in_ready=0 in HEADER.
  - The header does not count toward PAYLOAD_WORDS, so the frame carries PAYLOAD_WORDS+1 words.
- Undefined: the HEADER state and seq register are absent, and frames carry PAYLOAD_WORDS words.

Decomposition:
- Package tge_pkt_pkg holds: the state enum (IDLE, HEADER, PAYLOAD), the header field offsets (SEQ_MSB=63, LEN_MSB=31), and OVF_CNT_W=16.
- One sub-module, tge_sat_counter (parameterised width, saturating increment on a pulse), used for overflow_count.
- Everything else stays in the top.

Test Plan:
1. PAYLOAD_WORDS=4, macro off, continuous in_valid, data 1..8, dest 10.0.0.2:7148 -> two frames of 4 tx_valid words.
   - tx_end_of_frame on data 4 and 8, one idle cycle between frames.
   - frame_count=2; tx_dest_ip=32'h0A000002 throughout.
2. tx_afull=1 held before the first word -> in_ready=0 and no tx_valid. Release tx_afull -> the frame starts on the next cycle.
   - Assert tx_afull mid-frame -> the frame still completes with all 4 words.
3. in_last on the 2nd word, PAYLOAD_WORDS=4 -> a 2-word frame with EOF on word 2, frame_count=1, and the next frame has a full 4 words.
4. Macro on, PAYLOAD_WORDS=4 -> each frame has 5 words.
   - Word 0 of frame 0 = 64'h0000_0000_0004_0000.
   - Word 0 of frame 1 = 64'h0000_0001_0004_0000.
5. Pulse tx_overflow 3 times, then hold it high for 10 cycles -> overflow_count=4.
   - Preload the count near max: 70000 edges -> stays at 16'hFFFF.
6. Assert rst asynchronously mid-frame (word 2 of 4) -> all outputs go to 0 immediately, without waiting for a clock edge.
   - After release, the next frame starts clean with word_cnt=0 and the full 4 words.
